// File: rtl/distribute_pkg.sv
// distribute_pkg: sizing helpers shared by the distribute switch family
package distribute_pkg;
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    function automatic int res_cmd_width(input int in_w, input int n);
        return max_int(1, in_w - n);
    endfunction
endpackage

// File: rtl/distribute_out_slot.sv
// distribute_out_slot: single-entry output register with valid/ready and zero-on-drain
module distribute_out_slot #(
    parameter int DATA_WIDTH = 32,
    parameter int CMD_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [CMD_WIDTH-1:0]  cmd,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] q_data,
    output logic [CMD_WIDTH-1:0]  q_cmd,
    output logic                  loadable
);
    assign loadable = !valid || ready;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid  <= 1'b0;
            q_data <= '0;
            q_cmd  <= '0;
        end else if (load) begin
            valid  <= 1'b1;
            q_data <= data;
            q_cmd  <= cmd;
        end else if (ready) begin
            valid  <= 1'b0;
            q_data <= '0;
            q_cmd  <= '0;
        end
    end
endmodule

// File: rtl/distribute_1xn_cmd_flow_seq.sv
// distribute_1xn_cmd_flow_seq: registered 1-to-N multicast distribute stage peeling a destination mask off the command
module distribute_1xn_cmd_flow_seq
    import distribute_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int NUM_DATA_OUT     = 4,
    parameter int IN_COMMAND_WIDTH = 6,
    localparam int RES_CMD_WIDTH   = res_cmd_width(IN_COMMAND_WIDTH, NUM_DATA_OUT)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_en,
    input  logic                                  i_valid,
    output logic                                  i_ready,
    input  logic [DATA_WIDTH-1:0]                 i_data_bus,
    input  logic [IN_COMMAND_WIDTH-1:0]           i_cmd,
    output logic [NUM_DATA_OUT-1:0]               o_valid,
    input  logic [NUM_DATA_OUT-1:0]               o_ready,
    output logic [NUM_DATA_OUT*DATA_WIDTH-1:0]    o_data_bus,
    output logic [NUM_DATA_OUT*RES_CMD_WIDTH-1:0] o_cmd,
    output logic                                  o_drop
);
    logic [NUM_DATA_OUT-1:0]  mask, pend_mask, load, loadable;
    logic [RES_CMD_WIDTH-1:0] res, hold_cmd;
    logic [DATA_WIDTH-1:0]    hold_data;
    logic                     hs, accept;
    assign mask = i_cmd[IN_COMMAND_WIDTH-1 -: NUM_DATA_OUT];
    if (IN_COMMAND_WIDTH > NUM_DATA_OUT) begin : g_res
        assign res = i_cmd[IN_COMMAND_WIDTH-NUM_DATA_OUT-1:0];
    end else begin : g_nores
        assign res = '0;
    end
    always_comb begin
        load    = pend_mask & loadable;
        i_ready = i_en && !rst && ((pend_mask & ~loadable) == '0);
        hs      = i_valid && i_ready;
        accept  = hs && (mask != '0);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_mask <= '0;
            hold_data <= '0;
            hold_cmd  <= '0;
            o_drop    <= 1'b0;
        end else begin
            pend_mask <= accept ? mask : (pend_mask & ~load);
            o_drop    <= hs && (mask == '0);
            if (accept) begin
                hold_data <= i_data_bus;
                hold_cmd  <= res;
            end
        end
    end
    for (genvar g = 0; g < NUM_DATA_OUT; g++) begin : g_slot
        distribute_out_slot #(
            .DATA_WIDTH(DATA_WIDTH),
            .CMD_WIDTH (RES_CMD_WIDTH)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .load    (load[g]),
            .data    (hold_data),
            .cmd     (hold_cmd),
            .ready   (o_ready[g]),
            .valid   (o_valid[g]),
            .q_data  (o_data_bus[g*DATA_WIDTH +: DATA_WIDTH]),
            .q_cmd   (o_cmd[g*RES_CMD_WIDTH +: RES_CMD_WIDTH]),
            .loadable(loadable[g])
        );
    end
endmodule

// File: tb/tb_distribute_1xn_cmd_flow_seq.sv
// tb_distribute_1xn_cmd_flow_seq: directed checks of a 4-port mid stage and a 2-port last stage
module tb_distribute_1xn_cmd_flow_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    logic         a_en, a_valid, a_iready, a_drop;
    logic [31:0]  a_data;
    logic [5:0]   a_cmd;
    logic [3:0]   a_ovalid, a_oready;
    logic [127:0] a_odata;
    logic [7:0]   a_ocmd;
    logic         b_en, b_valid, b_iready, b_drop;
    logic [7:0]   b_data;
    logic [1:0]   b_cmd, b_ovalid, b_oready, b_ocmd;
    logic [15:0]  b_odata;
    int checks = 0;
    int failures = 0;
    distribute_1xn_cmd_flow_seq #(.DATA_WIDTH(32), .NUM_DATA_OUT(4), .IN_COMMAND_WIDTH(6)) u_a (
        .clk(clk), .rst(rst), .i_en(a_en), .i_valid(a_valid), .i_ready(a_iready),
        .i_data_bus(a_data), .i_cmd(a_cmd), .o_valid(a_ovalid), .o_ready(a_oready),
        .o_data_bus(a_odata), .o_cmd(a_ocmd), .o_drop(a_drop)
    );
    distribute_1xn_cmd_flow_seq #(.DATA_WIDTH(8), .NUM_DATA_OUT(2), .IN_COMMAND_WIDTH(2)) u_b (
        .clk(clk), .rst(rst), .i_en(b_en), .i_valid(b_valid), .i_ready(b_iready),
        .i_data_bus(b_data), .i_cmd(b_cmd), .o_valid(b_ovalid), .o_ready(b_oready),
        .o_data_bus(b_odata), .o_cmd(b_ocmd), .o_drop(b_drop)
    );
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    initial begin
        rst = 1'b1;
        a_en = 1'b1; a_valid = 1'b0; a_data = '0; a_cmd = '0; a_oready = 4'hF;
        b_en = 1'b1; b_valid = 1'b0; b_data = '0; b_cmd = '0; b_oready = 2'b11;
        tick();
        tick();
        check("rst_ovalid", a_ovalid, 4'h0);
        check("rst_odata", a_odata, 128'h0);
        check("rst_ocmd", a_ocmd, 8'h0);
        check("rst_drop", a_drop, 1'b0);
        check("rst_iready", a_iready, 1'b0);
        rst = 1'b0;
        #1;
        check("iready_after_rst", a_iready, 1'b1);
        a_valid = 1'b1; a_cmd = 6'b0100_10; a_data = 32'hA5A5A5A5;
        tick();
        a_valid = 1'b0;
        check("uni_no_early_valid", a_ovalid, 4'h0);
        tick();
        check("uni_ovalid", a_ovalid, 4'b0100);
        check("uni_odata", a_odata, {32'h0, 32'hA5A5A5A5, 64'h0});
        check("uni_ocmd", a_ocmd, 8'h20);
        tick();
        check("uni_drain_valid", a_ovalid, 4'h0);
        check("uni_drain_data", a_odata, 128'h0);
        a_valid = 1'b1; a_cmd = 6'b0001_00; a_data = 32'hD0D0D0D0;
        tick();
        a_cmd = 6'b1011_01; a_data = 32'h11223344; a_oready = 4'b1110;
        #1;
        check("mc_iready_pre", a_iready, 1'b1);
        tick();
        a_valid = 1'b0;
        #1;
        check("mc_iready_blocked", a_iready, 1'b0);
        tick();
        check("mc_partial_valid", a_ovalid, 4'b1011);
        check("mc_partial_data", a_odata, {32'h11223344, 32'h0, 32'h11223344, 32'hD0D0D0D0});
        check("mc_partial_cmd", a_ocmd, 8'h44);
        check("mc_iready_still", a_iready, 1'b0);
        tick();
        check("mc_stalled_valid", a_ovalid, 4'b0001);
        check("mc_stalled_data0", a_odata[31:0], 32'hD0D0D0D0);
        a_oready = 4'hF;
        #1;
        check("mc_iready_release", a_iready, 1'b1);
        tick();
        check("mc_port0_valid", a_ovalid, 4'b0001);
        check("mc_port0_data", a_odata, {96'h0, 32'h11223344});
        check("mc_port0_cmd", a_ocmd, 8'h01);
        check("mc_iready_after", a_iready, 1'b1);
        tick();
        check("mc_final_drain", a_ovalid, 4'h0);
        for (int i = 0; i < 8; i++) begin
            a_valid = (i < 6);
            a_cmd = 6'b1000_11;
            a_data = 32'h100 + i;
            #1;
            if (i < 6) check($sformatf("st_iready%0d", i), a_iready, 1'b1);
            tick();
            if (i >= 1 && i <= 6) begin
                check($sformatf("st_valid%0d", i - 1), a_ovalid, 4'b1000);
                check($sformatf("st_data%0d", i - 1), a_odata[127:96], 32'h100 + i - 1);
            end
        end
        check("st_idle", a_ovalid, 4'h0);
        a_valid = 1'b1; a_cmd = 6'b0000_11; a_data = 32'hDEADBEEF;
        #1;
        check("zm_iready", a_iready, 1'b1);
        tick();
        a_valid = 1'b0;
        check("zm_drop", a_drop, 1'b1);
        check("zm_ovalid", a_ovalid, 4'h0);
        tick();
        check("zm_drop_once", a_drop, 1'b0);
        check("zm_ovalid2", a_ovalid, 4'h0);
        check("zm_iready2", a_iready, 1'b1);
        a_en = 1'b0; a_valid = 1'b1; a_cmd = 6'b0010_00; a_data = 32'h0BAD0BAD;
        #1;
        check("en_iready", a_iready, 1'b0);
        tick();
        tick();
        check("en_nothing", a_ovalid, 4'h0);
        a_en = 1'b1; a_cmd = 6'b0100_00; a_data = 32'hE0E0E0E0;
        tick();
        a_en = 1'b0; a_cmd = 6'b0010_00; a_data = 32'h0BAD0BAD;
        #1;
        check("en_iready_held", a_iready, 1'b0);
        tick();
        check("en_drain_valid", a_ovalid, 4'b0100);
        check("en_drain_data", a_odata[95:64], 32'hE0E0E0E0);
        tick();
        check("en_no_capture", a_ovalid, 4'h0);
        a_valid = 1'b0; a_en = 1'b1;
        b_oready = 2'b00; b_valid = 1'b1; b_cmd = 2'b11; b_data = 8'h5C;
        tick();
        b_data = 8'h77;
        tick();
        b_valid = 1'b0;
        check("ls_valid", b_ovalid, 2'b11);
        check("ls_data", b_odata, 16'h5C5C);
        check("ls_cmd", b_ocmd, 2'b00);
        check("ls_iready_blocked", b_iready, 1'b0);
        rst = 1'b1;
        #1;
        check("ls_rst_valid", b_ovalid, 2'b00);
        check("ls_rst_data", b_odata, 16'h0);
        check("ls_rst_iready", b_iready, 1'b0);
        tick();
        rst = 1'b0;
        b_oready = 2'b11;
        tick();
        tick();
        check("ls_pending_lost", b_ovalid, 2'b00);
        check("ls_iready_free", b_iready, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/distribute_1xn_cmd_flow_seq.md
# distribute_1xN_cmd_flow_seq

Registered, back-pressured 1-to-N distribute switch with multicast, for use as one stage of a multi-stage distribution tree. It peels a destination bitmask off the head of the command, delivers the data word to every selected output, and forwards the residual command to the next stage. Each output has its own valid/ready handshake, so a stalled branch blocks only its own delivery. A multicast word completes once every targeted branch has taken it.

## Interface
Parameters:
- DATA_WIDTH, 32, payload width.
- NUM_DATA_OUT, 4, number of output ports; must be ≥2.
- IN_COMMAND_WIDTH, 6, input command width; must be ≥ NUM_DATA_OUT.
- RES_CMD_WIDTH (localparam) = max(1, IN_COMMAND_WIDTH − NUM_DATA_OUT), width of the residual command per port.

Ports (clock and reset first):
- clk  in  1  the single clock.
- rst  in  1  reset, asynchronous and active-high.
- i_en  in  1  switch enable; gates acceptance only.
- i_valid  in  1  input word valid.
- i_ready  out  1  input accept.
- i_data_bus  in  DATA_WIDTH  input payload.
- i_cmd  in  IN_COMMAND_WIDTH  command. Bits [IN_COMMAND_WIDTH-1 -: NUM_DATA_OUT] are the destination mask, with bit k selecting port k. The low bits are the residual.
- o_valid  out  NUM_DATA_OUT  per-port valid.
- o_ready  in  NUM_DATA_OUT  per-port ready from downstream.
- o_data_bus  out  NUM_DATA_OUT*DATA_WIDTH  port p occupies [p*DATA_WIDTH +: DATA_WIDTH].
- o_cmd  out  NUM_DATA_OUT*RES_CMD_WIDTH  port p occupies [p*RES_CMD_WIDTH +: RES_CMD_WIDTH].
- o_drop  out  1  one-cycle pulse when a word with an all-zero mask is accepted.

## Operation
Hold stage:
- Contents: a one-entry register holding hold_data, hold_cmd (residual), and pend_mask.
- The stage is empty when pend_mask == 0.

Acceptance:
- i_ready = i_en & !rst & (pend_mask == 0 | every set pend_mask bit is loadable this cycle).
- A handshake is i_valid & i_ready.
- On a handshake with a nonzero mask: load hold_data, load hold_cmd, and set pend_mask = mask.
- On a handshake with a zero mask: discard the word, pulse o_drop, and leave pend_mask unchanged.

Output slots:
- Each port has a single-entry register.
- Slot p is loadable when !o_valid[p] | o_ready[p].
- Each cycle, every port p with pend_mask[p]=1 and slot p loadable loads hold_data and hold_cmd, and pend_mask[p] clears.
- Partial multicast is allowed: ports that are ready take the word, and the remaining ports keep waiting.
- If a handshake coincides with the final pending bits clearing, the new word overwrites the hold stage. Throughput is one word per cycle when all targets are ready.
- A slot that drains (o_ready=1) without reloading sets o_valid[p]=0 and o_data/o_cmd to zero (dummy data is all zeros).

Residual and last stage:
- When IN_COMMAND_WIDTH == NUM_DATA_OUT, the residual is absent and o_cmd is tied to 0.

i_en:
- i_en=0 blocks new acceptance only. The hold stage and slots keep draining.

Validity rules:
- Words with i_valid=0 are ignored regardless of i_cmd.

## Timing
- Reset values: o_valid=0, o_data_bus=0, o_cmd=0, pend_mask=0, o_drop=0. i_ready=0 while rst is high.
- Latency from a handshake at edge k to o_valid at edge k+1 is one cycle of hold plus one cycle of slot load.
- The earliest o_valid after the handshake edge is 2 clock edges.
- No combinational path runs from i_valid to o_valid.
- The only combinational path from o_ready goes to i_ready.
- o_valid[p], once high, holds with stable data/cmd until o_ready[p]=1.
- Reset asserted mid-operation clears the hold stage and all slots immediately. In-flight words are lost.

## Structure
- Package distribute_pkg: a clog2/max helper function and the RES_CMD_WIDTH computation, shared with future distribute variants.
- Sub-module distribute_out_slot, one instance per port: a single-entry register with load, valid/ready, and zero-on-drain behaviour.
- The top level holds the hold stage, pend_mask logic, and i_ready generation.

## Test plan
- Unicast: NUM_DATA_OUT=4, i_cmd=6'b0100_10, data 0xA5A5A5A5, all o_ready=1 → after 2 edges, o_valid=4'b0100, port 2 data=0xA5A5A5A5, port 2 cmd=2'b10, all other ports zero.
- Multicast with a stall: mask 4'b1011, o_ready=4'b1110 → ports 1 and 3 are loaded, port 0 stays pending, and i_ready=0. Raising o_ready[0] loads port 0 on the next edge, after which i_ready=1.
- Streaming: a back-to-back unicast stream to port 3 with o_ready=1 → one word per cycle, in order, with no gaps.
- Zero mask: i_cmd=6'b0000_11 → o_drop pulses once, all o_valid stay 0, and i_ready stays 1.
- Last stage: IN_COMMAND_WIDTH=NUM_DATA_OUT=2, mask 2'b11 → both ports valid and o_cmd=0. Then assert rst while pending → all outputs are 0 within the reset cycle.
- Enable gating: i_en=0 with i_valid=1 → i_ready=0 and nothing is captured. A word already held still drains to its port.
